// File: rtl/timebase_monitor.sv
// timebase_monitor
// Checks the timer outputs medio_sg (half-second toggle) and latido (heartbeat
// pulse). It measures every medio_sg half-period and every latido high width
// in clock_in cycles and validates them against the parameters. It reports
// lock, sticky fault flags and the last two measurements.
//
// Ports:
//   clock_in    system clock, all logic on the rising edge
//   reset_btn   asynchronous active-high reset (driven from the timer's rst_out)
//   medio_sg    half-second toggle under test
//   latido      heartbeat pulse under test
//   clr_err     synchronous pulse: clear faults and counters, return to IDLE
//   locked      1 while in LOCKED
//   fault       1 while in FAULT
//   err_period  sticky: bad half-period while LOCKED
//   err_pulse   sticky: bad latido width or pulse outside the medio_sg high half
//   err_stuck   sticky: medio_sg did not toggle within 2*HALF_PERIOD cycles
//   per_last    last measured half-period, in cycles
//   pw_last     last measured latido width, in cycles
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for the first medio_sg toggle (not measured)
// ST_ACQUIRE | counting consecutive good half-periods up to LOCK_N
// ST_LOCKED  | timebase within tolerance; any bad period is a fault
// ST_FAULT   | error latched; left only by clr_err or reset_btn

module timebase_monitor #(
   parameter int CW          = 26,
   parameter int HALF_PERIOD = 6000000,
   parameter int TOL         = 1200,
   parameter int PULSE_LEN   = 1200001,
   parameter int PULSE_TOL   = 2,
   parameter int LOCK_N      = 4
) (
   input  logic          clock_in,
   input  logic          reset_btn,
   input  logic          medio_sg,
   input  logic          latido,
   input  logic          clr_err,
   output logic          locked,
   output logic          fault,
   output logic          err_period,
   output logic          err_pulse,
   output logic          err_stuck,
   output logic [CW-1:0] per_last,
   output logic [CW-1:0] pw_last
);

   // One extra bit so that "count + 1" and the bounds never wrap.
   localparam logic [CW:0] PER_MIN   = (CW+1)'(HALF_PERIOD - TOL);
   localparam logic [CW:0] PER_MAX   = (CW+1)'(HALF_PERIOD + TOL);
   localparam logic [CW:0] PW_MIN    = (CW+1)'(PULSE_LEN - PULSE_TOL);
   localparam logic [CW:0] PW_MAX    = (CW+1)'(PULSE_LEN + PULSE_TOL);
   localparam logic [CW:0] STUCK_LIM = (CW+1)'(2 * HALF_PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   state_t        state_q,      state_d;
   logic          medio_dly_q,  medio_dly_d;
   logic          latido_dly_q, latido_dly_d;
   logic [CW-1:0] per_cnt_q,    per_cnt_d;
   logic [CW-1:0] pw_cnt_q,     pw_cnt_d;
   logic [CW-1:0] good_cnt_q,   good_cnt_d;
   logic [CW-1:0] per_last_q,   per_last_d;
   logic [CW-1:0] pw_last_q,    pw_last_d;
   logic          err_period_q, err_period_d;
   logic          err_pulse_q,  err_pulse_d;
   logic          err_stuck_q,  err_stuck_d;
   logic          locked_q,     locked_d;
   logic          fault_q,      fault_d;

   logic          tog, rise, fall;
   logic [CW:0]   per_meas, pw_meas, pw_hi;
   logic [CW-1:0] good_inc;
   logic          per_good, pw_good, chk_on;
   logic          bad_period, bad_pulse, stuck;

   always_comb begin
      tog  = medio_sg ^ medio_dly_q;
      rise = latido & ~latido_dly_q;
      fall = ~latido & latido_dly_q;

      per_meas = {1'b0, per_cnt_q} + (CW+1)'(1);
      pw_meas  = {1'b0, pw_cnt_q} + (CW+1)'(1);
      // High samples seen so far including the current one.
      pw_hi    = rise ? (CW+1)'(1) : {1'b0, pw_cnt_q} + (CW+1)'(2);
      good_inc = good_cnt_q + CW'(1);

      per_good = (per_meas >= PER_MIN) && (per_meas <= PER_MAX);
      pw_good  = (pw_meas >= PW_MIN) && (pw_meas <= PW_MAX);
      chk_on   = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);

      bad_period = (state_q == ST_LOCKED) & tog & ~per_good;
      bad_pulse  = chk_on & ((fall & ~pw_good) |
                             (latido & (pw_hi > PW_MAX)) |
                             (rise & ~medio_sg));
      stuck      = ~tog & (per_meas >= STUCK_LIM);

      medio_dly_d  = medio_sg;
      latido_dly_d = latido;

      if (tog)
         per_cnt_d = '0;
      else if (&per_cnt_q)
         per_cnt_d = per_cnt_q;
      else
         per_cnt_d = per_cnt_q + CW'(1);

      if (rise)
         pw_cnt_d = '0;
      else if (latido && !(&pw_cnt_q))
         pw_cnt_d = pw_cnt_q + CW'(1);
      else
         pw_cnt_d = pw_cnt_q;

      // A saturated count reports as all-ones rather than wrapping to zero.
      per_last_d = per_last_q;
      if (tog && (state_q != ST_IDLE))
         per_last_d = per_meas[CW] ? '1 : per_meas[CW-1:0];

      pw_last_d = pw_last_q;
      if (fall)
         pw_last_d = pw_meas[CW] ? '1 : pw_meas[CW-1:0];

      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      err_period_d = err_period_q;
      err_pulse_d  = err_pulse_q;
      err_stuck_d  = err_stuck_q;

      case (state_q)
         ST_IDLE: begin
            if (tog)
               state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (tog) begin
               if (per_good) begin
                  good_cnt_d = good_inc;
                  if (good_inc >= CW'(LOCK_N))
                     state_d = ST_LOCKED;
               end else begin
                  good_cnt_d = '0;
               end
            end
         end
         default: ;
      endcase

      if (bad_period) err_period_d = 1'b1;
      if (bad_pulse)  err_pulse_d  = 1'b1;
      if (stuck)      err_stuck_d  = 1'b1;
      if (bad_period || bad_pulse || stuck)
         state_d = ST_FAULT;

      // clr_err overrides any error detected in the same cycle.
      if (clr_err) begin
         state_d      = ST_IDLE;
         per_cnt_d    = '0;
         pw_cnt_d     = '0;
         good_cnt_d   = '0;
         err_period_d = 1'b0;
         err_pulse_d  = 1'b0;
         err_stuck_d  = 1'b0;
      end

      locked_d = (state_d == ST_LOCKED);
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge clock_in or posedge reset_btn) begin
      if (reset_btn) begin
         state_q      <= ST_IDLE;
         medio_dly_q  <= 1'b0;
         latido_dly_q <= 1'b0;
         per_cnt_q    <= '0;
         pw_cnt_q     <= '0;
         good_cnt_q   <= '0;
         per_last_q   <= '0;
         pw_last_q    <= '0;
         err_period_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_stuck_q  <= 1'b0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         medio_dly_q  <= medio_dly_d;
         latido_dly_q <= latido_dly_d;
         per_cnt_q    <= per_cnt_d;
         pw_cnt_q     <= pw_cnt_d;
         good_cnt_q   <= good_cnt_d;
         per_last_q   <= per_last_d;
         pw_last_q    <= pw_last_d;
         err_period_q <= err_period_d;
         err_pulse_q  <= err_pulse_d;
         err_stuck_q  <= err_stuck_d;
         locked_q     <= locked_d;
         fault_q      <= fault_d;
      end
   end

   assign locked     = locked_q;
   assign fault      = fault_q;
   assign err_period = err_period_q;
   assign err_pulse  = err_pulse_q;
   assign err_stuck  = err_stuck_q;
   assign per_last   = per_last_q;
   assign pw_last    = pw_last_q;

endmodule
